// File: rtl/if_pkg.sv
// if_pkg: shared state type and constants for the instruction-fetch stage
package if_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT} if_state_t;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;
  localparam logic [31:0] PC_STEP = 32'd4;
endpackage

// File: rtl/if_out_buf.sv
// if_out_buf: single-entry instruction buffer feeding the IF/ID register
module if_out_buf
  import if_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        consume,
  input  logic        flush,
  input  logic [31:0] load_instr,
  input  logic [31:0] load_pc,
  output logic [31:0] instruct,
  output logic [31:0] next_pc,
  output logic        valid
);
  // flush beats load, load beats consume; next_pc is only ever rewritten by a load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      instruct <= NOP_INSTR;
      next_pc <= '0;
    end else if (flush || (consume && !load)) begin
      valid <= 1'b0;
      instruct <= NOP_INSTR;
    end else if (load) begin
      valid <= 1'b1;
      instruct <= load_instr;
      next_pc <= load_pc;
    end
  end
endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: PC + single-outstanding imem fetch FSM with stall/redirect handling
// Define IF_PERF_CNT_EN to add the perf_stall_cnt / perf_flush_cnt outputs.
module if_fetch_stage
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_PC,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] next_PC,
  output logic [31:0] instruct,
  output logic [5:0]  Opcode,
  output logic [5:0]  Funct,
  output logic        if_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);
  if_state_t state, state_nx;
  logic [31:0] pc, pc_nx;
  logic kill, kill_nx, load;
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      pc <= RESET_PC;
      kill <= 1'b0;
    end else begin
      state <= state_nx;
      pc <= pc_nx;
      kill <= kill_nx;
    end
  end
  // a response arriving while killed, or together with a redirect, is dropped
  always_comb begin
    state_nx = state;
    pc_nx = pc;
    kill_nx = kill;
    imem_req = 1'b0;
    load = 1'b0;
    case (state)
      IDLE: state_nx = REQ;
      REQ: begin
        imem_req = !redirect_i && (!if_valid || !stall_i);
        state_nx = imem_req ? WAIT : REQ;
      end
      WAIT: begin
        if (imem_rvalid) begin
          state_nx = REQ;
          kill_nx = 1'b0;
          load = !kill && !redirect_i;
          pc_nx = load ? pc + PC_STEP : pc;
        end else if (redirect_i) begin
          kill_nx = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (redirect_i) pc_nx = redirect_PC & ~32'd3;
  end
  assign imem_addr = imem_req ? pc : '0;
  if_out_buf #(.NOP_INSTR(NOP_INSTR)) u_buf (
    .clk(CLK),
    .rst_n(RST_N),
    .load(load),
    .consume(if_valid && !stall_i),
    .flush(redirect_i),
    .load_instr(imem_rdata),
    .load_pc(pc + PC_STEP),
    .instruct(instruct),
    .next_pc(next_PC),
    .valid(if_valid)
  );
  assign Opcode = instruct[OPCODE_MSB:OPCODE_LSB];
  assign Funct = instruct[FUNCT_MSB:FUNCT_LSB];
`ifdef IF_PERF_CNT_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      perf_stall_cnt <= perf_stall_cnt + {31'd0, if_valid && stall_i};
      perf_flush_cnt <= perf_flush_cnt + {31'd0, redirect_i};
    end
  end
`endif
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed stimulus, transaction-level model checked every cycle
module tb_if_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam logic [31:0] RPC = 32'h0000_0000;
  logic CLK = 1'b0, RST_N = 1'b0, stall_i = 1'b0, redirect_i = 1'b0, imem_rvalid = 1'b0;
  logic [31:0] redirect_PC = '0, imem_rdata = '0;
  logic imem_req, if_valid;
  logic [31:0] imem_addr, next_PC, instruct;
  logic [5:0] Opcode, Funct;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif
  if_fetch_stage dut (
    .CLK(CLK), .RST_N(RST_N), .stall_i(stall_i), .redirect_i(redirect_i),
    .redirect_PC(redirect_PC), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .next_PC(next_PC),
    .instruct(instruct), .Opcode(Opcode), .Funct(Funct), .if_valid(if_valid)
`ifdef IF_PERF_CNT_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );
  always #5 CLK = ~CLK;
  int n_cmp = 0, n_err = 0;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask
  logic [31:0] mem [logic [31:0]];
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : (a ^ 32'h1357_9BDF);
  endfunction
  logic q_req = 1'b0;
  logic [31:0] q_addr = '0, paddr = '0, last_addr = '0;
  logic pend = 1'b0;
  int cnt = 0, lat = 1;
  always @(negedge CLK) begin
    q_req <= imem_req;
    q_addr <= imem_addr;
  end
  // memory responder: answers each observed request after lat cycles
  task automatic tick();
    @(posedge CLK);
    #1;
    imem_rvalid = 1'b0;
    if (!RST_N) pend = 1'b0;
    else begin
      if (q_req) begin
        pend = 1'b1;
        cnt = lat;
        paddr = q_addr;
        last_addr = q_addr;
      end
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata = mem_rd(paddr);
          pend = 1'b0;
        end
      end
    end
  endtask
  task automatic wait_valid(input int bound);
    for (int i = 0; i < bound && !if_valid; i++) tick();
    chk("wait_valid", {31'd0, if_valid}, 32'd1);
  endtask
  // model: one fetch may be outstanding; a redirect cancels it; a 1-deep buffer holds the result
  logic m_idle, m_busy, m_cancel, m_v;
  logic [31:0] m_pc, m_ins, m_npc, m_sc, m_fc;
  task automatic model_reset();
    m_idle = 1'b1; m_busy = 1'b0; m_cancel = 1'b0; m_v = 1'b0;
    m_pc = RPC; m_ins = NOP; m_npc = '0; m_sc = '0; m_fc = '0;
  endtask
  task automatic model_step(input logic er);
    logic ld;
    ld = 1'b0;
    if (m_v && stall_i) m_sc++;
    if (redirect_i) m_fc++;
    if (m_busy && imem_rvalid) begin
      m_busy = 1'b0;
      if (!m_cancel && !redirect_i) begin
        ld = 1'b1;
        m_ins = imem_rdata;
        m_pc = m_pc + 4;
        m_npc = m_pc;
        m_v = 1'b1;
      end
      m_cancel = 1'b0;
    end else if (m_busy && redirect_i) m_cancel = 1'b1;
    if (redirect_i) begin
      m_pc = redirect_PC & ~32'd3;
      m_v = 1'b0;
      m_ins = NOP;
    end else if (!ld && m_v && !stall_i) begin
      m_v = 1'b0;
      m_ins = NOP;
    end
    if (er) m_busy = 1'b1;
    m_idle = 1'b0;
  endtask
  initial begin
    logic er;
    model_reset();
    forever begin
      @(negedge CLK);
      if (!RST_N) model_reset();
      er = RST_N && !m_idle && !m_busy && !redirect_i && (!m_v || !stall_i);
      chk("imem_req", {31'd0, imem_req}, {31'd0, er});
      if (er || !RST_N) chk("imem_addr", imem_addr, er ? m_pc : 32'd0);
      chk("if_valid", {31'd0, if_valid}, {31'd0, m_v});
      chk("instruct", instruct, m_ins);
      chk("next_PC", next_PC, m_npc);
      chk("Opcode", {26'd0, Opcode}, {26'd0, m_ins[31:26]});
      chk("Funct", {26'd0, Funct}, {26'd0, m_ins[5:0]});
`ifdef IF_PERF_CNT_EN
      chk("perf_stall_cnt", perf_stall_cnt, m_sc);
      chk("perf_flush_cnt", perf_flush_cnt, m_fc);
`endif
      @(posedge CLK);
      if (!RST_N) model_reset();
      else model_step(er);
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    mem[32'h0] = 32'h2108_0001;
    mem[32'h4] = 32'h0000_0020;
    mem[32'h8] = 32'hDEAD_BEEF;
    tick();
    tick();
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_instr", instruct, NOP);
    chk("rst_npc", next_PC, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    RST_N = 1'b1;
    // 1: two back-to-back fetches with 1-cycle memory
    wait_valid(10);
    chk("t1_addr0", last_addr, 32'h0);
    chk("t1_npc0", next_PC, 32'h4);
    chk("t1_op", {26'd0, Opcode}, 32'h08);
    tick();
    wait_valid(10);
    chk("t1_addr1", last_addr, 32'h4);
    chk("t1_npc1", next_PC, 32'h8);
    chk("t1_funct", {26'd0, Funct}, 32'h20);
    // 2: stall holds the buffer and blocks fetch
    stall_i = 1'b1;
    repeat (3) begin
      tick();
      #1;
      chk("t2_valid", {31'd0, if_valid}, 32'd1);
      chk("t2_instr", instruct, 32'h0000_0020);
      chk("t2_npc", next_PC, 32'h8);
      chk("t2_req", {31'd0, imem_req}, 32'd0);
    end
    stall_i = 1'b0;
    lat = 3;
    #1;
    chk("t2_resume_req", {31'd0, imem_req}, 32'd1);
    chk("t2_resume_addr", imem_addr, 32'h8);
`ifdef IF_PERF_CNT_EN
    chk("t2_perf_stall", perf_stall_cnt, 32'd3);
`endif
    // 3: redirect while waiting; the late word must be discarded
    tick();
    redirect_i = 1'b1;
    redirect_PC = 32'h0000_0103;
    tick();
    redirect_i = 1'b0;
    tick();
    tick();
    #1;
    chk("t3_valid", {31'd0, if_valid}, 32'd0);
    chk("t3_instr", instruct, NOP);
    chk("t3_req", {31'd0, imem_req}, 32'd1);
    chk("t3_addr", imem_addr, 32'h100);
    lat = 1;
    // 4: redirect overrides stall
    wait_valid(10);
    chk("t4_npc", next_PC, 32'h104);
    stall_i = 1'b1;
    redirect_i = 1'b1;
    redirect_PC = 32'h0000_0200;
    tick();
    redirect_i = 1'b0;
    stall_i = 1'b0;
    #1;
    chk("t4_valid", {31'd0, if_valid}, 32'd0);
    chk("t4_instr", instruct, NOP);
    chk("t4_req", {31'd0, imem_req}, 32'd1);
    chk("t4_addr", imem_addr, 32'h200);
    // 5: PC wraps from the top of the address space
    redirect_i = 1'b1;
    redirect_PC = 32'hFFFF_FFFF;
    tick();
    redirect_i = 1'b0;
    wait_valid(10);
    chk("t5_addr", last_addr, 32'hFFFF_FFFC);
    chk("t5_npc", next_PC, 32'h0);
    chk("t5_instr", instruct, 32'hFFFF_FFFC ^ 32'h1357_9BDF);
    #1;
    chk("t5_next_req", {31'd0, imem_req}, 32'd1);
    chk("t5_next_addr", imem_addr, 32'h0);
`ifdef IF_PERF_CNT_EN
    chk("t5_perf_flush", perf_flush_cnt, 32'd3);
`endif
    // 6: reset mid-fetch, stale response after release
    lat = 2;
    tick();
    RST_N = 1'b0;
    #1;
    chk("t6_rst_valid", {31'd0, if_valid}, 32'd0);
    chk("t6_rst_npc", next_PC, 32'd0);
    chk("t6_rst_req", {31'd0, imem_req}, 32'd0);
    tick();
    tick();
    RST_N = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata = 32'hBAD0_BAD0;
    tick();
    #1;
    chk("t6_valid", {31'd0, if_valid}, 32'd0);
    chk("t6_req", {31'd0, imem_req}, 32'd1);
    chk("t6_addr", imem_addr, RPC);
    wait_valid(10);
    chk("t6_instr", instruct, 32'h2108_0001);
    chk("t6_npc", next_PC, 32'h4);
    tick();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
